// File: rtl/regwb_pkg.sv
// Shared constants and types for the register-file write-back controller.
package regwb_pkg;

  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
  localparam int unsigned NREQ = 3;

  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_MEM = 1;
  localparam int unsigned REQ_MDU = 2;

  typedef logic [AW-1:0] reg_addr_t;

endpackage

// File: rtl/regwb_ctrl_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past each winner.
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;
  int unsigned   w_off;
  int unsigned   w_best_off;
  int unsigned   w_best;

  // Winner is the valid requester closest to the pointer going upward mod N.
  always_comb begin
    gnt        = '0;
    w_ptr_nxt  = r_ptr;
    w_off      = 0;
    w_best_off = N;
    w_best     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      w_off = (i + N - 32'(r_ptr)) % N;
      if (req[i] && (w_off < w_best_off)) begin
        w_best_off = w_off;
        w_best     = i;
      end
    end
    if (en && (w_best_off < N)) begin
      gnt       = N'(1) << w_best;
      w_ptr_nxt = PW'((w_best + 1) % N);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: rtl/regwb_ctrl.sv
// Register-file write-port sharing with round-robin arbitration and a busy scoreboard.
module regwb_ctrl #(
  parameter int unsigned NREQ = regwb_pkg::NREQ,
  parameter int unsigned AW   = regwb_pkg::AW,
  parameter int unsigned DW   = regwb_pkg::DW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_reg,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               wb_hold,
  output logic               rf_we,
  output logic [AW-1:0]      rf_wreg,
  output logic [DW-1:0]      rf_wdata,
  input  logic               rsv_valid,
  input  logic [AW-1:0]      rsv_reg,
  input  logic [AW-1:0]      chk_reg1,
  input  logic [AW-1:0]      chk_reg2,
  output logic               chk_busy1,
  output logic               chk_busy2,
  output logic [2**AW-1:0]   busy_vec,
  output logic               err
);

  localparam int unsigned NR = 2**AW;

  logic [NREQ-1:0] w_gnt;
  logic            w_en;
  logic            w_acc;
  logic            w_clr;
  logic            w_set;
  logic [AW-1:0]   w_wreg;
  logic [DW-1:0]   w_wdata;
  logic [NR-1:0]   w_busy_nxt;
  logic            w_err_nxt;

  logic [NR-1:0]   r_busy;
  logic            r_err;
  logic            r_we;
  logic [AW-1:0]   r_wreg;
  logic [DW-1:0]   r_wdata;

  assign w_en = ~wb_hold;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_valid),
    .en  (w_en),
    .gnt (w_gnt)
  );

  assign req_ready = w_gnt;

  // Select the granted requester's destination and data.
  always_comb begin
    w_acc   = |w_gnt;
    w_wreg  = '0;
    w_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_wreg  = req_reg[i*AW +: AW];
        w_wdata = req_data[i*DW +: DW];
      end
    end
  end

  // Scoreboard update: reservation set wins over a same-edge commit clear.
  always_comb begin
    w_clr      = w_acc && (w_wreg != '0);
    w_set      = rsv_valid && (rsv_reg != '0);
    w_busy_nxt = r_busy;
    if (w_clr) begin
      w_busy_nxt[w_wreg] = 1'b0;
    end
    if (w_set) begin
      w_busy_nxt[rsv_reg] = 1'b1;
    end
    w_err_nxt = r_err
              | (w_set && r_busy[rsv_reg] && !(w_clr && (w_wreg == rsv_reg)))
              | (w_clr && !r_busy[w_wreg]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= '0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_wreg  <= '0;
      r_wdata <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_err  <= w_err_nxt;
      r_we   <= w_clr;
      if (w_clr) begin
        r_wreg  <= w_wreg;
        r_wdata <= w_wdata;
      end
    end
  end

  assign rf_we     = r_we;
  assign rf_wreg   = r_wreg;
  assign rf_wdata  = r_wdata;
  assign busy_vec  = r_busy;
  assign err       = r_err;
  assign chk_busy1 = (chk_reg1 != '0) && r_busy[chk_reg1];
  assign chk_busy2 = (chk_reg2 != '0) && r_busy[chk_reg2];

endmodule
